// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file and its read ports.
package reg_file_pkg;

    localparam int unsigned REG_NUM_DEF  = 32;
    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ROB_ID_W_DEF = 4;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;
    // Alias value meaning "not renamed"; the ROB never allocates it.
    localparam logic [ROB_ID_W_DEF-1:0] RENAMED_ZERO = '0;

endpackage

// File: rtl/reg_file_read_port.sv
// Combinational operand query with same-cycle commit bypass; x0 reads as ready zero.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_NUM  = REG_NUM_DEF,
    parameter int unsigned ROB_ID_W = ROB_ID_W_DEF
) (
    input  logic [REG_IDX_W-1:0] i_idx,
    input  logic [DATA_W-1:0]    i_val   [REG_NUM],
    input  logic                 i_busy  [REG_NUM],
    input  logic [ROB_ID_W-1:0]  i_alias [REG_NUM],
    input  logic                 i_cmt_vld,
    input  logic [REG_IDX_W-1:0] i_cmt_idx,
    input  logic [DATA_W-1:0]    i_cmt_val,
    input  logic [ROB_ID_W-1:0]  i_cmt_alias,
    output logic                 o_busy,
    output logic [ROB_ID_W-1:0]  o_alias,
    output logic [DATA_W-1:0]    o_val
);

    logic w_hit;

    always_comb begin
        w_hit   = i_cmt_vld && (i_cmt_idx == i_idx) && (i_idx != REG_ZERO)
                  && i_busy[i_idx] && (i_alias[i_idx] == i_cmt_alias);
        o_busy  = 1'b0;
        o_alias = '0;
        o_val   = '0;
        if (i_idx == REG_ZERO) begin
            o_busy  = 1'b0;
        end else if (w_hit) begin
            o_val   = i_cmt_val;
        end else begin
            o_busy  = i_busy[i_idx];
            o_alias = i_alias[i_idx];
            o_val   = i_val[i_idx];
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags: commit writes, rename tagging,
// rollback flush and two combinational operand ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_NUM  = REG_NUM_DEF,
    parameter int unsigned ROB_ID_W = ROB_ID_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback_signal,
    input  logic                 res_rdy_from_rob,
    input  logic [REG_IDX_W-1:0] regidx_from_rob,
    input  logic [DATA_W-1:0]    res_from_rob,
    input  logic [ROB_ID_W-1:0]  alias_from_rob,
    input  logic                 rename_ena,
    input  logic [REG_IDX_W-1:0] rename_rd,
    input  logic [ROB_ID_W-1:0]  rename_alias,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_ID_W-1:0]  rs1_alias,
    output logic [ROB_ID_W-1:0]  rs2_alias,
    output logic [DATA_W-1:0]    rs1_val,
    output logic [DATA_W-1:0]    rs2_val
);

    logic [DATA_W-1:0]   r_val   [REG_NUM];
    logic                r_busy  [REG_NUM];
    logic [ROB_ID_W-1:0] r_alias [REG_NUM];

    logic w_cmt_wr;
    logic w_ren_wr;
    logic w_cmt_clr;

    always_comb begin
        w_cmt_wr  = res_rdy_from_rob && (regidx_from_rob != REG_ZERO);
        w_ren_wr  = rename_ena && (rename_rd != REG_ZERO);
        // A same-cycle rename of the committed register keeps it busy under the new tag.
        w_cmt_clr = w_cmt_wr && (r_alias[regidx_from_rob] == alias_from_rob)
                    && !(w_ren_wr && (rename_rd == regidx_from_rob));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                r_val[i]   <= '0;
                r_busy[i]  <= 1'b0;
                r_alias[i] <= '0;
            end
        end else if (rdy) begin
            if (w_cmt_wr) begin
                r_val[regidx_from_rob] <= res_from_rob;
            end
            if (rollback_signal) begin
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    r_busy[i]  <= 1'b0;
                    r_alias[i] <= '0;
                end
            end else begin
                if (w_cmt_clr) begin
                    r_busy[regidx_from_rob]  <= 1'b0;
                    r_alias[regidx_from_rob] <= '0;
                end
                if (w_ren_wr) begin
                    r_busy[rename_rd]  <= 1'b1;
                    r_alias[rename_rd] <= rename_alias;
                end
            end
        end
    end

    reg_read_port #(.REG_NUM(REG_NUM), .ROB_ID_W(ROB_ID_W)) u_rs1 (
        .i_idx       (rs1_idx),
        .i_val       (r_val),
        .i_busy      (r_busy),
        .i_alias     (r_alias),
        .i_cmt_vld   (res_rdy_from_rob),
        .i_cmt_idx   (regidx_from_rob),
        .i_cmt_val   (res_from_rob),
        .i_cmt_alias (alias_from_rob),
        .o_busy      (rs1_busy),
        .o_alias     (rs1_alias),
        .o_val       (rs1_val)
    );

    reg_read_port #(.REG_NUM(REG_NUM), .ROB_ID_W(ROB_ID_W)) u_rs2 (
        .i_idx       (rs2_idx),
        .i_val       (r_val),
        .i_busy      (r_busy),
        .i_alias     (r_alias),
        .i_cmt_vld   (res_rdy_from_rob),
        .i_cmt_idx   (regidx_from_rob),
        .i_cmt_val   (res_from_rob),
        .i_cmt_alias (alias_from_rob),
        .o_busy      (rs2_busy),
        .o_alias     (rs2_alias),
        .o_val       (rs2_val)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: commit, rename, bypass, rollback, x0 and stall behaviour.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback_signal;
    logic        res_rdy_from_rob;
    logic [4:0]  regidx_from_rob;
    logic [31:0] res_from_rob;
    logic [3:0]  alias_from_rob;
    logic        rename_ena;
    logic [4:0]  rename_rd;
    logic [3:0]  rename_alias;
    logic [4:0]  rs1_idx, rs2_idx;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_alias, rs2_alias;
    logic [31:0] rs1_val, rs2_val;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file #(.REG_NUM(32), .ROB_ID_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .rollback_signal  (rollback_signal),
        .res_rdy_from_rob (res_rdy_from_rob),
        .regidx_from_rob  (regidx_from_rob),
        .res_from_rob     (res_from_rob),
        .alias_from_rob   (alias_from_rob),
        .rename_ena       (rename_ena),
        .rename_rd        (rename_rd),
        .rename_alias     (rename_alias),
        .rs1_idx          (rs1_idx),
        .rs2_idx          (rs2_idx),
        .rs1_busy         (rs1_busy),
        .rs2_busy         (rs2_busy),
        .rs1_alias        (rs1_alias),
        .rs2_alias        (rs2_alias),
        .rs1_val          (rs1_val),
        .rs2_val          (rs2_val)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rollback_signal  = 1'b0;
        res_rdy_from_rob = 1'b0;
        regidx_from_rob  = '0;
        res_from_rob     = '0;
        alias_from_rob   = '0;
        rename_ena       = 1'b0;
        rename_rd        = '0;
        rename_alias     = '0;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] a);
        res_rdy_from_rob = 1'b1;
        regidx_from_rob  = rd;
        res_from_rob     = v;
        alias_from_rob   = a;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] a);
        rename_ena   = 1'b1;
        rename_rd    = rd;
        rename_alias = a;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        rs1_idx = '0;
        rs2_idx = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // reset state
        rs1_idx = 5'd5;
        #1;
        check("rst_busy", 32'(rs1_busy), 32'd0);
        check("rst_alias", 32'(rs1_alias), 32'd0);
        check("rst_val", rs1_val, 32'd0);

        // x0 ignores commit and rename
        commit(5'd0, 32'hDEAD, 4'd1);
        tick();
        idle();
        rename(5'd0, 4'd3);
        tick();
        idle();
        rs1_idx = 5'd0;
        rs2_idx = 5'd0;
        #1;
        check("x0_val", rs1_val, 32'd0);
        check("x0_busy", 32'(rs2_busy), 32'd0);
        check("x0_alias", 32'(rs2_alias), 32'd0);

        // rename then bypassed commit
        rename(5'd3, 4'd2);
        tick();
        idle();
        rs1_idx = 5'd3;
        #1;
        check("ren_busy", 32'(rs1_busy), 32'd1);
        check("ren_alias", 32'(rs1_alias), 32'd2);
        commit(5'd3, 32'h1234, 4'd2);
        #1;
        check("byp_busy", 32'(rs1_busy), 32'd0);
        check("byp_alias", 32'(rs1_alias), 32'd0);
        check("byp_val", rs1_val, 32'h1234);
        tick();
        idle();
        #1;
        check("cmt_busy", 32'(rs1_busy), 32'd0);
        check("cmt_val", rs1_val, 32'h1234);

        // older-alias commit after a second rename
        rename(5'd3, 4'd2);
        tick();
        rename(5'd3, 4'd5);
        tick();
        idle();
        commit(5'd3, 32'd7, 4'd2);
        rs2_idx = 5'd3;
        #1;
        check("old_nobyp_busy", 32'(rs2_busy), 32'd1);
        check("old_nobyp_val", rs2_val, 32'h1234);
        tick();
        idle();
        #1;
        check("old_val", rs2_val, 32'd7);
        check("old_busy", 32'(rs2_busy), 32'd1);
        check("old_alias", 32'(rs2_alias), 32'd5);
        commit(5'd3, 32'd9, 4'd5);
        tick();
        idle();
        #1;
        check("new_busy", 32'(rs2_busy), 32'd0);
        check("new_val", rs2_val, 32'd9);

        // same-cycle commit clear and rename on one register
        rename(5'd4, 4'd3);
        tick();
        idle();
        commit(5'd4, 32'hAB, 4'd3);
        rename(5'd4, 4'd6);
        rs1_idx = 5'd4;
        #1;
        check("cr_byp_val", rs1_val, 32'hAB);
        tick();
        idle();
        #1;
        check("cr_busy", 32'(rs1_busy), 32'd1);
        check("cr_alias", 32'(rs1_alias), 32'd6);
        check("cr_val", rs1_val, 32'hAB);

        // rollback with same-cycle commit and rename
        rename(5'd1, 4'd1);
        tick();
        rename(5'd2, 4'd2);
        tick();
        idle();
        rs1_idx = 5'd1;
        rs2_idx = 5'd2;
        #1;
        check("pre_rb_busy1", 32'(rs1_busy), 32'd1);
        check("pre_rb_alias2", 32'(rs2_alias), 32'd2);
        rollback_signal = 1'b1;
        commit(5'd7, 32'h55, 4'd7);
        rename(5'd8, 4'd3);
        tick();
        idle();
        #1;
        check("rb_busy1", 32'(rs1_busy), 32'd0);
        check("rb_alias1", 32'(rs1_alias), 32'd0);
        check("rb_busy2", 32'(rs2_busy), 32'd0);
        rs1_idx = 5'd7;
        rs2_idx = 5'd8;
        #1;
        check("rb_x7_val", rs1_val, 32'h55);
        check("rb_x8_busy", 32'(rs2_busy), 32'd0);
        check("rb_x8_alias", 32'(rs2_alias), 32'd0);
        rs1_idx = 5'd4;
        #1;
        check("rb_x4_busy", 32'(rs1_busy), 32'd0);

        // stall holds state, release applies pending ops
        rdy = 1'b0;
        rename(5'd9, 4'd4);
        commit(5'd9, 32'h99, 4'd4);
        rs1_idx = 5'd9;
        tick();
        tick();
        check("stall_busy", 32'(rs1_busy), 32'd0);
        check("stall_val", rs1_val, 32'd0);
        rdy = 1'b1;
        tick();
        idle();
        #1;
        check("rel_busy", 32'(rs1_busy), 32'd1);
        check("rel_alias", 32'(rs1_alias), 32'd4);
        check("rel_val", rs1_val, 32'h99);

        // reset clears stored values
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rs2_idx = 5'd3;
        #1;
        check("rst2_x9_busy", 32'(rs1_busy), 32'd0);
        check("rst2_x3_val", rs2_val, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
